// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator display scheduler.
package calc_disp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_CONV,
    S_HOLD
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g..a} patterns for digits 0..9
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/bcd_seg_decode.sv
// One BCD digit to an active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_seg_decode
  import calc_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Table lookup with dash fallback for 10..15
  always_comb begin
    o_seg = SEG_DASH;
    if (i_digit <= 4'd9) o_seg = SEG_TABLE[i_digit];
  end

endmodule

// File: rtl/calc_display_sched.sv
// Round-robin display scheduler: grants one requester, converts its 8-bit value
// to BCD by shift/add-3 over eight cycles, then holds the segments for a dwell time.
module calc_display_sched
  import calc_disp_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int HOLD_W      = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] val,
  output logic [NREQ-1:0]   ack,
  output logic [6:0]        seg_ones,
  output logic [6:0]        seg_tens,
  output logic [6:0]        seg_hund,
  output logic [2:0]        active_id,
  output logic              busy
);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_rr_ptr, r_win, w_win, w_idx;
  logic [3:0]        w_sum;
  logic              w_any;
  logic [7:0]        w_req_pad;
  logic [63:0]       w_val_pad;
  logic [7:0]        w_val_sel;
  logic [7:0]        r_bin;
  logic [11:0]       r_bcd, w_bcd_adj, w_bcd_shift;
  logic [2:0]        r_iter;
  logic [HOLD_W-1:0] r_hold;
  logic [NREQ-1:0]   r_ack;
  logic [6:0]        r_seg_ones, r_seg_tens, r_seg_hund;
  logic [6:0]        w_seg_o, w_seg_t, w_seg_h;
  logic [2:0]        r_active_id;
  logic              r_busy;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Padding to eight requesters lets the pointer index the vectors at full width
  assign w_req_pad = 8'(req);
  assign w_val_pad = 64'(val);
  assign w_val_sel = w_val_pad[{r_win, 3'b000} +: 8];

  // Round-robin search: first set request at or after the pointer, wrapping at NREQ
  always_comb begin
    w_any = 1'b0;
    w_win = r_rr_ptr;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 4'(k);
      if (w_sum >= 4'(NREQ)) w_sum = w_sum - 4'(NREQ);
      w_idx = w_sum[2:0];
      if (!w_any && w_req_pad[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next binary bit
  always_comb begin
    w_bcd_adj   = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    w_bcd_shift = {w_bcd_adj[10:0], r_bin[7]};
  end

  bcd_seg_decode u_dec_ones (.i_digit(w_bcd_shift[3:0]),  .o_seg(w_seg_o));
  bcd_seg_decode u_dec_tens (.i_digit(w_bcd_shift[7:4]),  .o_seg(w_seg_t));
  bcd_seg_decode u_dec_hund (.i_digit(w_bcd_shift[11:8]), .o_seg(w_seg_h));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = S_CONV;
      S_CONV:  if (r_iter == 3'd7) w_state_nxt = S_HOLD;
      S_HOLD:  if (r_hold == HOLD_W'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Control registers: grant pulse, pointer, iteration/dwell counters, display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack       <= '0;
      r_busy      <= 1'b0;
      r_active_id <= '0;
      r_rr_ptr    <= '0;
      r_win       <= '0;
      r_iter      <= '0;
      r_hold      <= '0;
      r_seg_ones  <= SEG_DASH;
      r_seg_tens  <= SEG_DASH;
      r_seg_hund  <= SEG_DASH;
    end else begin
      r_ack  <= '0;
      r_busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ack <= NREQ'(1) << w_win;
            r_win <= w_win;
          end
        end
        S_GRANT: begin
          r_active_id <= r_win;
          r_rr_ptr    <= (r_win == 3'(NREQ - 1)) ? 3'd0 : r_win + 3'd1;
          r_iter      <= '0;
        end
        S_CONV: begin
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd7) begin
            r_seg_ones <= w_seg_o;
            r_seg_tens <= (w_bcd_shift[11:4] == 8'd0) ? SEG_BLANK : w_seg_t;
            r_seg_hund <= (w_bcd_shift[11:8] == 4'd0) ? SEG_BLANK : w_seg_h;
            r_hold     <= HOLD_W'(HOLD_CYCLES);
          end
        end
        S_HOLD:  r_hold <= r_hold - HOLD_W'(1);
        default: r_hold <= r_hold;
      endcase
    end
  end

  // Conversion datapath: load on grant, shift during conversion
  always_ff @(posedge clk) begin
    if (r_state == S_GRANT) begin
      r_bin <= w_val_sel;
      r_bcd <= '0;
    end else if (r_state == S_CONV) begin
      r_bin <= {r_bin[6:0], 1'b0};
      r_bcd <= w_bcd_shift;
    end
  end

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign active_id = r_active_id;
  assign seg_ones  = r_seg_ones;
  assign seg_tens  = r_seg_tens;
  assign seg_hund  = r_seg_hund;

endmodule

// File: tb/tb_calc_display_sched.sv
// Self-checking bench for calc_display_sched with a short dwell time.
`timescale 1ns/1ps
module tb_calc_display_sched;

  localparam int NREQ = 3;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] val;
  logic [2:0]  ack;
  logic [6:0]  seg_ones, seg_tens, seg_hund;
  logic [2:0]  active_id;
  logic        busy;

  calc_display_sched #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .HOLD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .val(val), .ack(ack),
    .seg_ones(seg_ones), .seg_tens(seg_tens), .seg_hund(seg_hund),
    .active_id(active_id), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] TBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  typedef struct {
    logic [2:0]  ack;
    logic [2:0]  id;
    logic [20:0] segs;
  } exp_t;

  typedef struct {
    int id;
    int value;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [20:0] ref_segs(input int v);
    int h, t, o;
    logic [6:0] sh, st, so;
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    sh = (h == 0) ? BLANK : TBL[h];
    st = (h == 0 && t == 0) ? BLANK : TBL[t];
    so = TBL[o];
    return {sh, st, so};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard monitor: pop on every ack, then check display and dwell timing
  initial begin : monitor
    exp_t cur;
    bit   pend;
    int   age;
    pend = 0;
    age  = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pend = 0;
      end else begin
        if (pend) begin
          age++;
          if (age == 9) begin
            chk("segs", {seg_hund, seg_tens, seg_ones}, cur.segs);
            chk("active_id", active_id, cur.id);
            chk("busy_hold_start", busy, 1);
          end
          if (age == 12) chk("busy_hold_end", busy, 1);
          if (age == 13) begin
            chk("busy_idle", busy, 0);
            pend = 0;
          end
        end
        if (ack != 3'b000) begin
          if (sbq.size() == 0) begin
            chk("unexpected_ack", ack, 0);
          end else begin
            cur = sbq.pop_front();
            chk("ack", ack, cur.ack);
            pend = 1;
            age  = 0;
          end
        end
      end
    end
  end

  task automatic push_exp(input int id, input int v);
    exp_t e;
    e.ack  = 3'(1 << id);
    e.id   = 3'(id);
    e.segs = ref_segs(v);
    sbq.push_back(e);
  endtask

  task automatic wait_ack(input int id);
    bit got;
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ack[id]) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("idle_timeout", 0, 1);
  endtask

  task automatic serve(input int id, input int v, input bit pulse);
    push_exp(id, v);
    val[id*8 +: 8] = 8'(v);
    req[id] = 1'b1;
    wait_ack(id);
    @(posedge clk); #1;
    req[id] = 1'b0;
    if (pulse) begin
      repeat (8) @(posedge clk);
      #1 req[2] = 1'b1;
      @(posedge clk);
      #1 req[2] = 1'b0;
    end
    wait_idle();
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    vec_t vecs[8];
    int   ack2;
    vecs = '{'{0, 255}, '{0, 7}, '{2, 40}, '{1, 100},
             '{2, 0}, '{0, 9}, '{1, 10}, '{2, 199}};

    rst_n = 1'b0;
    req   = '0;
    val   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hund", seg_hund, DASH);
    chk("rst_tens", seg_tens, DASH);
    chk("rst_ones", seg_ones, DASH);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active_id", active_id, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) serve(vecs[i].id, vecs[i].value, 1'b0);

    // Reset in the middle of a conversion
    push_exp(1, 55);
    val[15:8] = 8'd55;
    req[1] = 1'b1;
    wait_ack(1);
    @(posedge clk); #1 req[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_hund", seg_hund, DASH);
    chk("midrst_tens", seg_tens, DASH);
    chk("midrst_ones", seg_ones, DASH);
    chk("midrst_ack", ack, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_active_id", active_id, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // All three requesting continuously: order follows the pointer from 0
    push_exp(0, 11);
    push_exp(1, 22);
    push_exp(2, 33);
    push_exp(0, 11);
    val = {8'd33, 8'd22, 8'd11};
    req = 3'b111;
    wait_ack(0);
    wait_ack(1);
    wait_ack(2);
    wait_ack(0);
    @(posedge clk); #1 req = 3'b000;
    wait_idle();
    @(posedge clk); #1;

    // Short request pulse during the dwell must be dropped
    serve(0, 123, 1'b1);
    ack2 = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack[2]) ack2++;
    end
    chk("pulse_no_ack2", ack2, 0);
    chk("pulse_display_kept", {seg_hund, seg_tens, seg_ones}, ref_segs(123));
    chk("pulse_busy", busy, 0);
    @(posedge clk); #1;

    // Full value sweep on requester 1
    for (int v = 0; v < 256; v++) serve(1, v, 1'b0);

    repeat (5) @(posedge clk);
    chk("queue_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
